// File: rtl/reg_file_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_param: multi-read, single-write register file with power-up sweep  |
// | Optional: REG_FILE_PARAM_BYPASS_EN enables write-to-read forwarding.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module reg_file_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic                ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            rd_live;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    case (state_q)
      ST_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: ;
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // The sweep owns the write port during CLEAR; user writes are only honoured in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_data = wdata;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        wr_data = '0;
      end else begin
        wr_en = we && !((ZERO_REG != 0) && (waddr == '0));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rd_live = (state_q == ST_RUN) && !reset;

  generate
    for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0]   lane_addr;
      logic            zero_hit;
      logic [XLEN-1:0] lane_data;

      assign lane_addr = raddr[g*AW +: AW];
      assign zero_hit  = (ZERO_REG != 0) && (lane_addr == '0);

      always_comb begin
        lane_data = '0;
        if (rd_live && !zero_hit) begin
`ifdef REG_FILE_PARAM_BYPASS_EN
          if (we && (lane_addr == waddr)) begin
            lane_data = wdata;
          end else begin
            lane_data = regs_q[lane_addr];
          end
`else
          lane_data = regs_q[lane_addr];
`endif
        end
      end

      assign rdata[g*XLEN +: XLEN] = lane_data;
    end
  endgenerate

  assign ready = ready_q;

endmodule
`default_nettype wire
